// File: rtl/ramdisk_ptr_ctrl_if.sv
// Slot-bus and SRAM-side signals of the RAM-disk pointer controller.
// The controller uses the slave view; the bus/SRAM environment uses the master view.
interface ramdisk_ptr_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic              PHI1;
  logic              nDEVSEL;
  logic              nIOSEL;
  logic [3:0]        A;
  logic              nWE;
  logic [7:0]        Din;
  logic [7:0]        RDin;
  logic [7:0]        Dout;
  logic              DOE;
  logic              RDOE;
  logic [ADDR_W-1:0] RA;
  logic              RAMCS;
  logic              REGEN;

  modport master (
    output PHI1, nDEVSEL, nIOSEL, A, nWE, Din, RDin,
    input  Dout, DOE, RDOE, RA, RAMCS, REGEN
  );

  modport slave (
    input  PHI1, nDEVSEL, nIOSEL, A, nWE, Din, RDin,
    output Dout, DOE, RDOE, RA, RAMCS, REGEN
  );
endinterface

// File: rtl/ramdisk_ptr_ctrl.sv
// RAM-disk pointer controller: NPTR auto-stepping SRAM address pointers behind the
// Apple II slot bus, with the carry/borrow rippled one byte per PHI1 state (S1..S3).
module ramdisk_ptr_ctrl #(
  parameter int ADDR_W = 20,
  parameter int NPTR   = 2
) (
  input  logic              C7M,
  input  logic              RES,
  ramdisk_ptr_ctrl_if.slave bus
);

  localparam int         HW     = ADDR_W - 16;
  localparam logic [2:0] NPTR_L = 3'(NPTR);
  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_INC  = 2'b01;
  localparam logic [1:0] M_DEC  = 2'b10;
  localparam logic [1:0] M_BAD  = 2'b11;

  function automatic logic [7:0] step8(input logic [7:0] v, input logic dec);
    return dec ? v - 8'd1 : v + 8'd1;
  endfunction

  function automatic logic [HW-1:0] step_hi(input logic [HW-1:0] v, input logic dec);
    return dec ? v - HW'(1) : v + HW'(1);
  endfunction

  function automatic logic wraps8(input logic [7:0] v, input logic dec);
    return dec ? (v == 8'h00) : (v == 8'hFF);
  endfunction

  // A byte write that crosses bit 7 in the stepping direction owes the next byte a carry/borrow.
  function automatic logic carry_sched(input logic old7, input logic new7, input logic [1:0] m);
    return ((m == M_INC) && old7 && !new7) || ((m == M_DEC) && !old7 && new7);
  endfunction

  logic [2:0]              s;
  logic [2:0]              s_next;
  logic                    phi1_q;
  logic                    phi0_seen;
  logic                    rise;
  logic                    csdben;
  logic                    regen;
  logic [1:0]              psel;
  logic [3:0][1:0]         mode;
  logic [3:0][ADDR_W-1:0]  ptr;

  logic [1:0]              sidx_p0;
  logic                    sdec_p0;
  logic                    stp_lo_p0;
  logic                    c_mid_p1;
  logic                    c_hi_p2;

  logic                    access;
  logic                    ram_sel;
  logic                    at_s5;
  logic                    wr;
  logic                    wr_lo;
  logic                    wr_mid;
  logic                    wr_hi;
  logic                    wr_ctl;
  logic                    ctl_ok;
  logic                    port_s5;
  logic                    sched_mid;
  logic                    sched_hi;
  logic                    latch_step;
  logic                    do_lo;
  logic                    do_mid;
  logic                    do_hi;
  logic [ADDR_W-1:0]       cur_ptr;
  logic [1:0]              cur_mode;
  logic [ADDR_W-1:0]       stp_ptr;
  logic [7:0]              hi_rd;
  logic [7:0]              rd_mux;

  assign rise = bus.PHI1 & ~phi1_q & phi0_seen;

  always_comb begin
    s_next = s;
    if (rise)
      s_next = 3'd1;
    else if (s != 3'd0 && s != 3'd7)
      s_next = s + 3'd1;
  end

  assign cur_ptr  = ptr[psel];
  assign cur_mode = mode[psel];
  assign stp_ptr  = ptr[sidx_p0];

  assign access   = regen & ~bus.nDEVSEL;
  assign ram_sel  = access & (bus.A == 4'd3);
  assign at_s5    = (s == 3'd5);
  assign wr       = access & ~bus.nWE & at_s5;
  assign wr_lo    = wr & (bus.A == 4'd0);
  assign wr_mid   = wr & (bus.A == 4'd1);
  assign wr_hi    = wr & (bus.A == 4'd2);
  assign wr_ctl   = wr & (bus.A == 4'd4);
  // An out-of-range PSEL drops the whole control write, mode field included.
  assign ctl_ok   = ({1'b0, bus.Din[1:0]} < NPTR_L);

  assign port_s5    = ram_sel & at_s5;
  assign sched_mid  = wr_lo  & carry_sched(cur_ptr[7],  bus.Din[7], cur_mode);
  assign sched_hi   = wr_mid & carry_sched(cur_ptr[15], bus.Din[7], cur_mode);
  assign latch_step = port_s5 | sched_mid | sched_hi;

  assign do_lo  = (s == 3'd1) & stp_lo_p0;
  assign do_mid = (s == 3'd2) & c_mid_p1;
  assign do_hi  = (s == 3'd3) & c_hi_p2;

  always_ff @(posedge C7M) begin
    if (RES) begin
      s         <= 3'd0;
      phi1_q    <= 1'b0;
      phi0_seen <= 1'b0;
      csdben    <= 1'b0;
      regen     <= 1'b0;
      psel      <= 2'd0;
      mode      <= {4{M_INC}};
      ptr       <= '0;
      sidx_p0   <= 2'd0;
      sdec_p0   <= 1'b0;
      stp_lo_p0 <= 1'b0;
      c_mid_p1  <= 1'b0;
      c_hi_p2   <= 1'b0;
    end else begin
      s         <= s_next;
      phi1_q    <= bus.PHI1;
      phi0_seen <= phi0_seen | ~bus.PHI1;
      csdben    <= (s >= 3'd4);
      if (s == 3'd4 && !bus.nIOSEL)
        regen <= 1'b1;

      if (wr_ctl && ctl_ok) begin
        psel <= bus.Din[1:0];
        if (bus.Din[5:4] != M_BAD)
          mode[bus.Din[1:0]] <= bus.Din[5:4];
      end

      // S5: capture the step target; later PSEL changes do not redirect it
      if (latch_step) begin
        sidx_p0 <= psel;
        sdec_p0 <= (cur_mode == M_DEC);
      end
      if (port_s5)
        stp_lo_p0 <= (cur_mode != M_HOLD);
      else if (do_lo)
        stp_lo_p0 <= 1'b0;

      // S1: low byte step, carry into mid
      if (sched_mid)
        c_mid_p1 <= 1'b1;
      else if (do_lo)
        c_mid_p1 <= wraps8(stp_ptr[7:0], sdec_p0);
      else if (do_mid)
        c_mid_p1 <= 1'b0;

      // S2: mid byte step, carry into high; S3 consumes it
      if (sched_hi)
        c_hi_p2 <= 1'b1;
      else if (do_mid)
        c_hi_p2 <= wraps8(stp_ptr[15:8], sdec_p0);
      else if (do_hi)
        c_hi_p2 <= 1'b0;

      for (int i = 0; i < NPTR; i++) begin
        if (wr_lo && psel == 2'(i))
          ptr[i][7:0] <= bus.Din;
        else if (do_lo && sidx_p0 == 2'(i))
          ptr[i][7:0] <= step8(ptr[i][7:0], sdec_p0);

        if (wr_mid && psel == 2'(i))
          ptr[i][15:8] <= bus.Din;
        else if (do_mid && sidx_p0 == 2'(i))
          ptr[i][15:8] <= step8(ptr[i][15:8], sdec_p0);

        if (wr_hi && psel == 2'(i))
          ptr[i][ADDR_W-1:16] <= bus.Din[HW-1:0];
        else if (do_hi && sidx_p0 == 2'(i))
          ptr[i][ADDR_W-1:16] <= step_hi(ptr[i][ADDR_W-1:16], sdec_p0);
      end
    end
  end

  always_comb begin
    hi_rd         = 8'hFF;
    hi_rd[HW-1:0] = cur_ptr[ADDR_W-1:16];
    case (bus.A)
      4'd0:    rd_mux = cur_ptr[7:0];
      4'd1:    rd_mux = cur_ptr[15:8];
      4'd2:    rd_mux = hi_rd;
      4'd3:    rd_mux = bus.RDin;
      4'd4:    rd_mux = {2'b00, cur_mode, 2'b00, psel};
      default: rd_mux = 8'h00;
    endcase
  end

  assign bus.Dout  = access ? rd_mux : 8'h00;
  assign bus.DOE   = csdben & bus.nWE & access;
  // RES gates the chip select directly so the SRAM is released before the reset edge.
  assign bus.RAMCS = ram_sel & csdben & ~RES;
  assign bus.RDOE  = bus.RAMCS & ~bus.nWE;
  assign bus.RA    = cur_ptr;
  assign bus.REGEN = regen;

endmodule

// File: tb/tb_ramdisk_ptr_ctrl.sv
// Directed bench for ramdisk_ptr_ctrl: each bus cycle is seven C7M clocks with PHI1
// high for the first three, so S runs 1..7 and register writes land on the S5 edge.
module tb_ramdisk_ptr_ctrl;
  localparam int ADDR_W = 20;
  localparam int NPTR   = 2;

  logic C7M = 1'b0;
  logic RES = 1'b1;
  int   errs   = 0;
  int   checks = 0;

  ramdisk_ptr_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  ramdisk_ptr_ctrl #(.ADDR_W(ADDR_W), .NPTR(NPTR)) dut (
    .C7M (C7M),
    .RES (RES),
    .bus (bus)
  );

  always #5 C7M = ~C7M;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One bus cycle, started and ended on a falling edge; outputs sampled during S6.
  task automatic cyc(input logic dev, input logic io, input logic [3:0] a,
                     input logic wr, input logic [7:0] d,
                     output logic [7:0] dout, output logic ramcs,
                     output logic rdoe, output logic doe);
    bus.PHI1    = 1'b1;
    bus.nDEVSEL = ~dev;
    bus.nIOSEL  = ~io;
    bus.A       = a;
    bus.nWE     = ~wr;
    bus.Din     = d;
    repeat (3) @(negedge C7M);
    bus.PHI1 = 1'b0;
    repeat (3) @(negedge C7M);
    dout  = bus.Dout;
    ramcs = bus.RAMCS;
    rdoe  = bus.RDOE;
    doe   = bus.DOE;
    @(negedge C7M);
    bus.nDEVSEL = 1'b1;
    bus.nIOSEL  = 1'b1;
    bus.nWE     = 1'b1;
  endtask

  task automatic idle();
    logic [7:0] x;
    logic c, o, e;
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, x, c, o, e);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] x;
    logic c, o, e;
    cyc(1'b1, 1'b0, a, 1'b1, d, x, c, o, e);
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
    logic c, o, e;
    cyc(1'b1, 1'b0, a, 1'b0, 8'h00, d, c, o, e);
  endtask

  task automatic rd_ptr(output logic [23:0] v);
    logic [7:0] b0, b1, b2;
    rd_reg(4'd0, b0);
    rd_reg(4'd1, b1);
    rd_reg(4'd2, b2);
    v = {b2, b1, b0};
  endtask

  // Load a pointer in hold mode so the byte writes schedule no carries, then set its mode.
  task automatic set_ptr(input logic [1:0] p, input logic [19:0] v, input logic [1:0] m);
    wr_reg(4'd4, {6'b000000, p});
    wr_reg(4'd0, v[7:0]);
    wr_reg(4'd1, v[15:8]);
    wr_reg(4'd2, {4'h0, v[19:16]});
    wr_reg(4'd4, {2'b00, m, 2'b00, p});
  endtask

  task automatic test_reset();
    logic [7:0]  d;
    logic [23:0] v;
    logic        c, o, e;
    RES = 1'b1;
    repeat (3) @(negedge C7M);
    checks++; if (bus.RA !== 20'h00000) begin errs++; $display("FAIL reset_ra: got %h want 00000", bus.RA); end
    checks++; if (bus.RAMCS !== 1'b0) begin errs++; $display("FAIL reset_ramcs: got %b want 0", bus.RAMCS); end
    checks++; if (bus.RDOE !== 1'b0) begin errs++; $display("FAIL reset_rdoe: got %b want 0", bus.RDOE); end
    checks++; if (bus.DOE !== 1'b0) begin errs++; $display("FAIL reset_doe: got %b want 0", bus.DOE); end
    checks++; if (bus.Dout !== 8'h00) begin errs++; $display("FAIL reset_dout: got %h want 00", bus.Dout); end
    checks++; if (bus.REGEN !== 1'b0) begin errs++; $display("FAIL reset_regen: got %b want 0", bus.REGEN); end
    RES = 1'b0;
    // PHI1 stuck high since reset: S must stay 0, so IOSEL cannot reach S4
    bus.nIOSEL = 1'b0;
    repeat (8) @(negedge C7M);
    checks++; if (bus.REGEN !== 1'b0) begin errs++; $display("FAIL no_phi0_regen: got %b want 0", bus.REGEN); end
    bus.nIOSEL = 1'b1;
    idle();
    wr_reg(4'd0, 8'h55);
    cyc(1'b0, 1'b1, 4'd0, 1'b0, 8'h00, d, c, o, e);
    checks++; if (bus.REGEN !== 1'b1) begin errs++; $display("FAIL iosel_regen: got %b want 1", bus.REGEN); end
    rd_ptr(v);
    checks++; if (v !== 24'hF00000) begin errs++; $display("FAIL early_write_ignored: got %h want F00000", v); end
    cyc(1'b1, 1'b0, 4'd4, 1'b0, 8'h00, d, c, o, e);
    checks++; if (d !== 8'h10) begin errs++; $display("FAIL reset_ctrl: got %h want 10", d); end
    checks++; if (e !== 1'b1) begin errs++; $display("FAIL read_doe: got %b want 1", e); end
  endtask

  task automatic test_inc_carry();
    logic [7:0]  d;
    logic [23:0] v;
    logic        c, o, e;
    set_ptr(2'd0, 20'h0FFFF, 2'b01);
    bus.RDin = 8'hA5;
    cyc(1'b1, 1'b0, 4'd3, 1'b0, 8'h00, d, c, o, e);
    checks++; if (d !== 8'hA5) begin errs++; $display("FAIL port_read_data: got %h want A5", d); end
    checks++; if (c !== 1'b1) begin errs++; $display("FAIL port_read_ramcs: got %b want 1", c); end
    checks++; if (o !== 1'b0) begin errs++; $display("FAIL port_read_rdoe: got %b want 0", o); end
    checks++; if (bus.RA !== 20'h0FFFF) begin errs++; $display("FAIL ra_before_step: got %h want 0FFFF", bus.RA); end
    idle();
    checks++; if (bus.RA !== 20'h10000) begin errs++; $display("FAIL inc_carry_ra: got %h want 10000", bus.RA); end
    rd_ptr(v);
    checks++; if (v !== 24'hF10000) begin errs++; $display("FAIL inc_carry_ptr: got %h want F10000", v); end
  endtask

  task automatic test_dec_borrow();
    logic [7:0]  d;
    logic [23:0] v;
    logic        c, o, e;
    wr_reg(4'd4, 8'h21);
    rd_reg(4'd4, d);
    checks++; if (d !== 8'h21) begin errs++; $display("FAIL ctrl_21: got %h want 21", d); end
    cyc(1'b1, 1'b0, 4'd3, 1'b1, 8'h77, d, c, o, e);
    checks++; if (c !== 1'b1) begin errs++; $display("FAIL port_write_ramcs: got %b want 1", c); end
    checks++; if (o !== 1'b1) begin errs++; $display("FAIL port_write_rdoe: got %b want 1", o); end
    checks++; if (e !== 1'b0) begin errs++; $display("FAIL port_write_doe: got %b want 0", e); end
    idle();
    checks++; if (bus.RA !== 20'hFFFFF) begin errs++; $display("FAIL dec_borrow_ra: got %h want FFFFF", bus.RA); end
    rd_ptr(v);
    checks++; if (v !== 24'hFFFFFF) begin errs++; $display("FAIL dec_borrow_ptr: got %h want FFFFFF", v); end
    wr_reg(4'd4, 8'h10);
    rd_ptr(v);
    checks++; if (v !== 24'hF10000) begin errs++; $display("FAIL ptr0_untouched: got %h want F10000", v); end
  endtask

  task automatic test_psel_invalid();
    logic [7:0] d;
    wr_reg(4'd4, 8'h03);
    rd_reg(4'd4, d);
    checks++; if (d !== 8'h10) begin errs++; $display("FAIL psel_out_of_range: got %h want 10", d); end
    checks++; if (bus.RA !== 20'h10000) begin errs++; $display("FAIL psel_ra_kept: got %h want 10000", bus.RA); end
    wr_reg(4'd4, 8'h31);
    rd_reg(4'd4, d);
    checks++; if (d !== 8'h21) begin errs++; $display("FAIL mode11_ignored: got %h want 21", d); end
  endtask

  task automatic test_write_carry();
    logic [23:0] v;
    set_ptr(2'd0, 20'h00080, 2'b01);
    wr_reg(4'd0, 8'h00);
    idle();
    checks++; if (bus.RA !== 20'h00100) begin errs++; $display("FAIL lo_write_carry_ra: got %h want 00100", bus.RA); end
    rd_ptr(v);
    checks++; if (v !== 24'hF00100) begin errs++; $display("FAIL lo_write_carry_ptr: got %h want F00100", v); end
    set_ptr(2'd1, 20'h30000, 2'b10);
    wr_reg(4'd1, 8'h80);
    idle();
    checks++; if (bus.RA !== 20'h28000) begin errs++; $display("FAIL mid_write_borrow_ra: got %h want 28000", bus.RA); end
    rd_ptr(v);
    checks++; if (v !== 24'hF28000) begin errs++; $display("FAIL mid_write_borrow_ptr: got %h want F28000", v); end
  endtask

  task automatic test_hold();
    logic [7:0] d;
    logic       c, o, e;
    wr_reg(4'd4, 8'h01);
    cyc(1'b1, 1'b0, 4'd3, 1'b0, 8'h00, d, c, o, e);
    idle();
    checks++; if (bus.RA !== 20'h28000) begin errs++; $display("FAIL hold_no_step: got %h want 28000", bus.RA); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       c, o, e;
    set_ptr(2'd0, 20'h000FE, 2'b01);
    cyc(1'b1, 1'b0, 4'd3, 1'b0, 8'h00, d, c, o, e);
    cyc(1'b1, 1'b0, 4'd3, 1'b0, 8'h00, d, c, o, e);
    checks++; if (bus.RA !== 20'h000FF) begin errs++; $display("FAIL b2b_first_step: got %h want 000FF", bus.RA); end
    idle();
    checks++; if (bus.RA !== 20'h00100) begin errs++; $display("FAIL b2b_second_step: got %h want 00100", bus.RA); end
  endtask

  task automatic test_res_mid();
    logic [7:0]  d;
    logic [23:0] v;
    logic        c, o, e;
    set_ptr(2'd0, 20'h12345, 2'b01);
    bus.PHI1    = 1'b1;
    bus.nDEVSEL = 1'b0;
    bus.A       = 4'd3;
    bus.nWE     = 1'b1;
    repeat (3) @(negedge C7M);
    bus.PHI1 = 1'b0;
    repeat (2) @(negedge C7M);
    checks++; if (bus.RAMCS !== 1'b1) begin errs++; $display("FAIL s5_ramcs: got %b want 1", bus.RAMCS); end
    RES = 1'b1;
    #1;
    checks++; if (bus.RAMCS !== 1'b0) begin errs++; $display("FAIL res_ramcs_now: got %b want 0", bus.RAMCS); end
    @(negedge C7M);
    checks++; if (bus.RAMCS !== 1'b0) begin errs++; $display("FAIL res_ramcs_next: got %b want 0", bus.RAMCS); end
    checks++; if (bus.RA !== 20'h00000) begin errs++; $display("FAIL res_ra: got %h want 00000", bus.RA); end
    checks++; if (bus.REGEN !== 1'b0) begin errs++; $display("FAIL res_regen: got %b want 0", bus.REGEN); end
    RES = 1'b0;
    bus.nDEVSEL = 1'b1;
    idle();
    cyc(1'b0, 1'b1, 4'd0, 1'b0, 8'h00, d, c, o, e);
    rd_ptr(v);
    checks++; if (v !== 24'hF00000) begin errs++; $display("FAIL res_ptr0: got %h want F00000", v); end
    wr_reg(4'd4, 8'h11);
    rd_ptr(v);
    checks++; if (v !== 24'hF00000) begin errs++; $display("FAIL res_ptr1: got %h want F00000", v); end
  endtask

  initial begin
    bus.PHI1    = 1'b1;
    bus.nDEVSEL = 1'b1;
    bus.nIOSEL  = 1'b1;
    bus.A       = 4'd0;
    bus.nWE     = 1'b1;
    bus.Din     = 8'h00;
    bus.RDin    = 8'h00;
    @(negedge C7M);
    test_reset();
    test_inc_carry();
    test_dec_borrow();
    test_psel_invalid();
    test_write_carry();
    test_hold();
    test_back_to_back();
    test_res_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ramdisk_ptr_ctrl.md
# ramdisk_ptr_ctrl

Parametrised RAM-disk pointer controller for the Apple II slot card CPLD. Next generation of the single auto-incrementing "slinky" address register: it provides NPTR independent ADDR_W-bit pointers. Each pointer has its own step mode (hold, increment, decrement), and the carry or borrow ripples byte-serially across the PHI1 states. The block sits between the 6502 slot bus (/DEVSEL, /IOSEL) and the SRAM address and chip-select pins.

## Interface
Parameters:
- ADDR_W, 20, pointer width. Legal range 17..24.
- NPTR, 2, number of pointers. Legal range 1..4.

Ports:
- C7M  in  1  7 MHz bus clock. The only clock.
- RES  in  1  reset. Synchronous, active-high.
- PHI1  in  1  PHI1, already hold-time delayed upstream.
- nDEVSEL, nIOSEL  in  1 each  slot selects, active-low.
- A  in  4  6502 A[3:0].
- nWE  in  1  6502 R/W (1 = read).
- Din  in  8  6502 data bus, write data.
- RDin  in  8  SRAM data, read data.
- Dout  out  8  data presented to the 6502 bus.
- DOE  out  1  6502 data bus drive enable.
- RDOE  out  1  SRAM data bus drive enable.
- RA  out  ADDR_W  SRAM address. Equals the selected pointer.
- RAMCS  out  1  SRAM chip select, active-high.
- REGEN  out  1  register enable status.

## Operation
- Phase counter S (3 bits):
  - Reset value 0.
  - Any cycle: S <= 1 when PHI1 is high, PHI1 was low on the previous cycle, and PHI0 has been seen (PHI1 sampled low at least once since reset).
  - Otherwise, S=0 holds at 0 and S=7 saturates at 7; all other values increment.
- CSDBEN register: loads 1 when S is 4..7 on the clock edge, else 0.
- REGEN:
  - Set at the end of S4 when nIOSEL=0.
  - Cleared only by RES.
  - All register access below requires REGEN=1 and nDEVSEL=0.
- Register map, decoded from A[3:0]:
  - 0 = pointer low byte, 1 = pointer mid byte, 2 = pointer high byte (ADDR_W-16 bits).
  - 3 = data port.
  - 4 = control.
  - Other addresses: reads return 0x00, writes are ignored.
- Control register (write):
  - Din[1:0] -> PSEL. Ignored if the value is >= NPTR; PSEL is then unchanged.
  - Din[5:4] -> MODE[new PSEL]: 00 hold, 01 increment, 10 decrement. Value 11 is ignored.
- Control register (read): {2'b00, MODE[PSEL], 2'b00, PSEL}.
- Pointer byte reads: return the bytes of P[PSEL]. The high byte reads with its unused upper bits as 1s.
- Pointer byte writes:
  - Load the byte at the end of S5.
  - Low-byte write in increment mode with old bit7=1 and new bit7=0 schedules a mid-byte carry.
  - Mid-byte write under the same condition schedules a high-byte carry.
  - In decrement mode the mirrored rule applies: old bit7=0 and new bit7=1 schedules a borrow.
- Data port:
  - RAMSEL = REGEN & ~nDEVSEL & (A=3).
  - RAMCS = RAMSEL & CSDBEN.
  - RDOE = RAMCS & ~nWE.
  - Reads: Dout = RDin.
- DOE = CSDBEN & nWE & REGEN & ~nDEVSEL.
- Step pipeline:
  - At the end of S5 of a data-port access, latch the step pointer index (= PSEL) and its mode.
  - S1: low byte ±1. Carry/borrow out is latched when the low byte was FF (increment) or 00 (decrement).
  - S2: mid byte ±1 if the carry/borrow flag is set.
  - S3: high byte ±1 if the carry/borrow flag is set.
  - The address wraps modulo 2^ADDR_W; no flag is raised.
  - Mode hold: no step.

## Timing
- Reset values: S=0, REGEN=0, CSDBEN=0, PSEL=0, all MODE=01, all pointers 0, step flags 0. Outputs DOE=0, RDOE=0, RAMCS=0, Dout=0x00, RA=0.
- Register writes take effect on the C7M edge ending S5. Readback is visible in the next bus cycle.
- RA updates combinationally with PSEL and pointer contents. It reflects the low-byte step one cycle after S1, and the full step after S3, before the next S4.
- Step flags are cleared once consumed (S1, S2, S3 respectively).
- Simultaneous events: a pointer byte write at S5 overrides any pending step for that byte. The step pipeline never overlaps an S5 write because it runs only in S1..S3.
- PSEL change while a step is pending: the step still applies to the latched pointer index.
- RES mid-cycle: all state returns to reset values on the next edge and RAMCS drops immediately. A pending step is discarded.
- Without a PHI0 observed since reset, S stays 0 and no register is writable.

## Test plan
- Reset, then IOSEL access at S4 -> REGEN=1. A write before the IOSEL access is ignored; the pointer still reads 0.
- PSEL=0, MODE inc, pointer=0x0FFFF, data-port read -> after the next S3 the pointer reads 0x10000, and RA follows.
- Write control 0x21 (PSEL=1, decrement), pointer1=0x00000, data-port write -> pointer1 becomes 0xFFFFF. Pointer0 is unchanged.
- Write control 0x03 with NPTR=2 -> PSEL stays at its prior value and MODE is unchanged.
- Increment mode, low byte 0x80, write 0x00 to low byte -> mid byte increments by 1 at the next S2.
- Assert RES during S5 of a data-port access -> no step, RAMCS=0 next cycle, all pointers 0.
